// File: rtl/scd_pkg.sv
// scd_pkg: shared types and the SCAD arithmetic helper for the shift-count
// datapath. Optional build macro used by the block: SCD_SATURATE_EN.
package scd_pkg;

  // SCAD operation codes as decoded from the control field.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,  // A + B
    OP_SUB = 3'd1,  // A - B  (A + ~B + 1)
    OP_INC = 3'd2,  // A + 1
    OP_DEC = 3'd3,  // A - 1  (A + all-ones)
    OP_A   = 3'd4,  // pass A
    OP_B   = 3'd5,  // pass B
    OP_OR  = 3'd6,  // A | B
    OP_AND = 3'd7   // A & B
  } scad_op_t;

  // Shift-loop sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } scd_state_t;

  // Widest datapath the helper supports.
  localparam int SCD_MAX_W = 16;

  // Width-generic SCAD evaluation on zero-extended operands. Only the low
  // w bits of a and b are looked at. The return value is {cry0, result}
  // packed at width w+1 (carry in bit w); all bits above w are zero.
  // Logic ops never produce a carry.
  function automatic logic [16:0] scad_compute(input logic [15:0] a,
                                               input logic [15:0] b,
                                               input scad_op_t    op,
                                               input int unsigned w);
    logic [16:0] mask;
    logic [16:0] x;
    logic [16:0] y;
    logic [16:0] cin;
    logic [16:0] s;
    mask = (17'd1 << w) - 17'd1;
    x    = {1'b0, a} & mask;
    y    = '0;
    cin  = '0;
    s    = '0;
    case (op)
      OP_ADD: begin
        y = {1'b0, b} & mask;
        s = x + y + cin;
      end
      OP_SUB: begin
        y   = {1'b0, ~b} & mask;
        cin = 17'd1;
        s   = x + y + cin;
      end
      OP_INC: begin
        cin = 17'd1;
        s   = x + y + cin;
      end
      OP_DEC: begin
        y = mask;
        s = x + y + cin;
      end
      OP_A:    s = x;
      OP_B:    s = {1'b0, b} & mask;
      OP_OR:   s = (x | {1'b0, b}) & mask;
      OP_AND:  s = (x & {1'b0, b}) & mask;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scd_if.sv
// scd_if: control/status bundle between the EBOX control decode (master)
// and the shift-count datapath (slave). Adds ovf when SCD_SATURATE_EN is
// defined.
//
// Handshake: the master pulses start for one cycle while busy is low. The
// slave raises busy for every RUN cycle; each cycle that busy, step_en is
// high and abort is low is one accepted shift, flagged by shift_strb in
// that same cycle. done pulses for exactly one cycle when the loop ends
// (normally, by abort or by stall error). start while the loop is active
// is ignored.
interface scd_if #(parameter int W = 10);
  import scd_pkg::*;

  // master -> slave
  logic [W-1:0] scada;
  logic [W-1:0] scadb;
  logic [2:0]   scad_op;
  logic         ld_fe;
  logic         ld_sc;
  logic         start;
  logic         step_en;
  logic         abort;

  // slave -> master
  logic [W-1:0] scad;
  logic         scad_eq0;
  logic         scad_sign;
  logic         cry0;
  logic [W-1:0] fe;
  logic [W-1:0] sc;
  logic         fe_sign;
  logic         sc_sign;
  logic         sc_ge_limit;
  logic         busy;
  logic         shift_strb;
  logic         done;
  logic         stall_err;
`ifdef SCD_SATURATE_EN
  logic         ovf;
`endif
  scd_state_t   dbg_state;

  modport master (
    output scada, scadb, scad_op, ld_fe, ld_sc, start, step_en, abort,
    input  scad, scad_eq0, scad_sign, cry0, fe, sc, fe_sign, sc_sign,
           sc_ge_limit, busy, shift_strb, done, stall_err,
`ifdef SCD_SATURATE_EN
           ovf,
`endif
           dbg_state
  );

  modport slave (
    input  scada, scadb, scad_op, ld_fe, ld_sc, start, step_en, abort,
    output scad, scad_eq0, scad_sign, cry0, fe, sc, fe_sign, sc_sign,
           sc_ge_limit, busy, shift_strb, done, stall_err,
`ifdef SCD_SATURATE_EN
           ovf,
`endif
           dbg_state
  );

endinterface

// File: rtl/scd_alu.sv
// scd_alu: purely combinational W-bit SCAD adder/logic unit.
// With SCD_SATURATE_EN defined, arithmetic ops clamp to the signed range on
// overflow and report it on o_ovf; cry0 always reflects the raw add.
module scd_alu
  import scd_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  scad_op_t     i_op,
  output logic [W-1:0] o_result,
  output logic         o_cry0
`ifdef SCD_SATURATE_EN
  ,
  output logic         o_ovf
`endif
);

  logic [16:0]  w_raw;
  logic [W-1:0] w_sum;

  // Raw wrapped result with the carry packed just above it.
  always_comb begin
    w_raw = scad_compute(16'(i_a), 16'(i_b), i_op, W);
  end

  assign w_sum  = W'(w_raw);
  assign o_cry0 = 1'(w_raw >> W);

`ifdef SCD_SATURATE_EN
  logic [W-1:0] w_y;
  logic         w_arith;
  logic         w_ovf;

  // Effective second adder operand, used only to judge signed overflow.
  always_comb begin
    w_y     = '0;
    w_arith = 1'b1;
    case (i_op)
      OP_ADD:  w_y = i_b;
      OP_SUB:  w_y = ~i_b;
      OP_INC:  w_y = '0;
      OP_DEC:  w_y = '1;
      default: w_arith = 1'b0;
    endcase
  end

  // Like-signed operands producing an opposite-signed sum is an overflow.
  assign w_ovf    = w_arith && (i_a[W-1] == w_y[W-1]) && (w_sum[W-1] != i_a[W-1]);
  assign o_ovf    = w_ovf;
  assign o_result = !w_ovf    ? w_sum :
                    i_a[W-1]  ? {1'b1, {(W-1){1'b0}}} :
                                {1'b0, {(W-1){1'b1}}};
`else
  assign o_result = w_sum;
`endif

endmodule

// File: rtl/scd_counter.sv
// scd_counter: parametrised SCAD unit feeding the FE and SC registers, plus
// a shift-loop sequencer that counts SC down with one shift strobe per step.
// Optional build macro: SCD_SATURATE_EN (saturating arithmetic + ovf).
module scd_counter
  import scd_pkg::*;
#(
  parameter int W         = 10,
  parameter int LIMIT     = 36,
  parameter int STALL_MAX = 0
) (
  input  logic  clk,
  input  logic  CROBAR,
  scd_if.slave  bus
);

  // Counter just wide enough to hold STALL_MAX.
  localparam int CW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  logic [W-1:0]  w_scad;
  logic          w_cry0;
`ifdef SCD_SATURATE_EN
  logic          w_ovf;
`endif
  logic          w_sc_zero;
  logic          w_sc_one;
  logic          w_strb;
  logic [CW-1:0] w_stall_next;
  logic          w_stall_hit;

  logic [W-1:0]  r_fe;
  logic [W-1:0]  r_sc;
  scd_state_t    r_state;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_stall_cnt;
  logic          r_stall_err;

  scd_alu #(.W(W)) u_alu (
    .i_a      (bus.scada),
    .i_b      (bus.scadb),
    .i_op     (scad_op_t'(bus.scad_op)),
    .o_result (w_scad),
    .o_cry0   (w_cry0)
`ifdef SCD_SATURATE_EN
    ,
    .o_ovf    (w_ovf)
`endif
  );

  assign w_sc_zero    = (r_sc == '0);
  assign w_sc_one     = (r_sc == W'(1));
  // Abort wins over step_en, so an aborting cycle never strobes.
  assign w_strb       = (r_state == RUN) && bus.step_en && !bus.abort;
  assign w_stall_next = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + CW'(1);
  assign w_stall_hit  = (STALL_MAX != 0) && (w_stall_next >= CW'(STALL_MAX));

  // FE follows ld_fe unconditionally, including while the loop runs.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_fe <= '0;
    end else if (bus.ld_fe) begin
      r_fe <= w_scad;
    end
  end

  // Sequencer; owns SC while in RUN so ld_sc only lands outside RUN.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_sc        <= '0;
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ld_sc) begin
            r_sc <= w_scad;
          end
          if (bus.start) begin
            r_stall_err <= 1'b0;
            r_stall_cnt <= '0;
            // Negative or zero count: nothing to shift, finish at once.
            if (r_sc[W-1] || w_sc_zero) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_state     <= FIN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_stall_cnt <= '0;
          end else if (bus.step_en) begin
            r_sc        <= r_sc - W'(1);
            r_stall_cnt <= '0;
            if (w_sc_one) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (w_stall_hit) begin
            r_stall_err <= 1'b1;
            r_state     <= FIN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= w_stall_next;
          end
        end
        FIN: begin
          if (bus.ld_sc) begin
            r_sc <= w_scad;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scad        = w_scad;
  assign bus.scad_eq0    = (w_scad == '0);
  assign bus.scad_sign   = w_scad[W-1];
  assign bus.cry0        = w_cry0;
`ifdef SCD_SATURATE_EN
  assign bus.ovf         = w_ovf;
`endif
  assign bus.fe          = r_fe;
  assign bus.sc          = r_sc;
  assign bus.fe_sign     = r_fe[W-1];
  assign bus.sc_sign     = r_sc[W-1];
  assign bus.sc_ge_limit = !r_sc[W-1] && (r_sc >= W'(LIMIT));
  assign bus.busy        = r_busy;
  assign bus.shift_strb  = w_strb;
  assign bus.done        = r_done;
  assign bus.stall_err   = r_stall_err;
  assign bus.dbg_state   = r_state;

endmodule

// File: doc/scd_counter.md
Name: scd_counter

Overview:
- Parametrised shift-count datapath: W-bit SCAD adder/logic unit feeding FE and SC registers, plus a shift-loop sequencer that counts SC down and emits one shift strobe per step.
- Generalises the fixed 10-bit FE/SC arrangement with the hard "SC >= 36" compare.
- Sits between the CRAM-decoded control fields and the shifter/normaliser in the EBOX.
- Adds a start/busy/done handshake and a programmable limit compare.

Parameters:
- W, 10, width of SCADA, SCADB, SCAD result, FE and SC, in bits. Legal range 4..16.
- LIMIT, 36, constant for the sc_ge_limit compare (unsigned, SC >= LIMIT). Must fit in W-1 bits.
- STALL_MAX, 0, if nonzero, the maximum consecutive step_en-low cycles tolerated while RUN before a stall error. 0 disables the check.

Ports:
- clk  in  1  system clock
- CROBAR  in  1  asynchronous active-high reset
- scada  in  W  SCAD A operand
- scadb  in  W  SCAD B operand
- scad_op  in  3  0:A+B 1:A-B 2:A+1 3:A-1 4:A 5:B 6:A|B 7:A&B
- ld_fe  in  1  FE <= SCAD result
- ld_sc  in  1  SC <= SCAD result
- start  in  1  begin shift loop using current SC
- step_en  in  1  shifter ready; loop advances only when high
- abort  in  1  terminate loop
- scad  out  W  combinational SCAD result
- scad_eq0  out  1  scad == 0
- scad_sign  out  1  scad[MSB]
- cry0  out  1  carry out of bit 0 (MSB) for ops 0..3, else 0
- fe  out  W  FE register
- sc  out  W  SC register
- fe_sign  out  1  fe[MSB]
- sc_sign  out  1  sc[MSB]
- sc_ge_limit  out  1  sc not negative and sc >= LIMIT
- busy  out  1  loop in RUN
- shift_strb  out  1  one-cycle pulse per SC decrement
- done  out  1  one-cycle pulse at loop end
- stall_err  out  1  sticky; STALL_MAX exceeded

Behaviour:
- Reset (async, CROBAR high):
  - fe, sc = 0; state IDLE.
  - busy, shift_strb, done, stall_err = 0; stall counter = 0.
- SCAD result:
  - Arithmetic is W-bit modular two's complement.
  - A-B is computed as A + ~B + 1. cry0 is the true carry out of that W-bit add (borrow-free gives 1).
- FE and SC loads:
  - FE and SC load on the clk edge when their load enable is high.
  - ld_fe and ld_sc may both be high in one cycle; both registers receive the same result.
- ld_sc priority:
  - ld_sc is ignored while busy. The loop owns SC.
  - ld_fe is always honoured.
- Sequencer states IDLE, RUN, FIN:
  - IDLE: start high with sc_sign=1 or sc==0 -> FIN, no strobes.
  - IDLE: start high with sc > 0 -> RUN.
  - RUN, step_en high:
    - sc <= sc-1 and shift_strb=1 that cycle (combinational from state and step_en).
    - If sc==1 -> FIN.
  - RUN, step_en low: hold; increment the stall counter.
  - RUN, abort high: -> FIN next edge; takes priority over step_en, no strobe that cycle; SC retains its value.
  - FIN: done=1 for exactly one cycle, then -> IDLE.
  - start asserted outside IDLE is ignored.
- Strobe count:
  - Exactly N shift_strb pulses for a starting SC of N > 0.
  - Minimum latency start -> done is N+1 cycles.
- Stall counter:
  - Cleared on any step_en-high cycle and on leaving RUN.
  - When STALL_MAX != 0 and the counter reaches STALL_MAX: stall_err sets and the state moves to FIN.
  - stall_err clears only on reset or on the next start.
- Reset mid-loop: immediate IDLE with all outputs at their reset values. No done pulse.

Optional Feature:
- Macro: SCD_SATURATE_EN.
- With the macro defined:
  - Ops 0..3 saturate to the most positive or most negative W-bit value on signed overflow.
  - Output ovf (1 bit) is added and is high on any overflowing cycle.
  - cry0 still reports the unsaturated carry.
- Without the macro: results wrap modulo 2^W and the ovf port is absent.

Decomposition:
- Package scd_pkg holds:
  - enum scad_op_t (8 codes above);
  - enum scd_state_t {IDLE, RUN, FIN};
  - function scad_compute(a, b, op), parameterised via width argument, returning {cry0, result}.
- Sub-module scd_alu:
  - Purely combinational SCAD unit, parameter W.
  - Instantiated once.
  - Contains the saturation logic under SCD_SATURATE_EN.

Test Plan:
- W=10: scada=36, scadb=0, op=4, ld_sc -> sc=36, sc_ge_limit=1; reload 35 -> sc_ge_limit=0; reload 0x3FF -> sc_sign=1, sc_ge_limit=0.
- sc=5, start, step_en tied high -> exactly 5 shift_strb pulses on consecutive cycles, done in cycle 6, sc=0, busy low after.
- sc=4, start, step_en low on cycles 2-3 -> strobes only on high cycles, total 4, done delayed 2 cycles; STALL_MAX=3 -> no stall_err.
- sc=10, start, abort after 3 strobes -> done next cycle, sc=7, no further strobes; ld_sc during RUN ignored.
- op=1, scada=0, scadb=1 -> scad=0x3FF, scad_sign=1, cry0=0; op=0, 0x3FF+1 -> scad=0, scad_eq0=1, cry0=1. With SCD_SATURATE_EN: 0x1FF+1 -> 0x1FF, ovf=1.
- CROBAR pulsed mid-RUN (sc=8 after 2 strobes) -> fe=sc=0, busy=0, no done. STALL_MAX=2 with step_en low 2 cycles -> stall_err=1, done pulse.
